// File: rtl/trap_if.sv
// trap_if: exception, flush, redirect, CSR and status signals of the trap controller.
// master drives requests, pipe status and CSR access; slave is the controller.
interface trap_if;
   logic        exc_valid;
   logic [31:0] exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret_valid;
   logic        exc_ready;
   logic        flush;
   logic        pipe_empty;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        trap_active;
   logic        flush_timeout;

   modport master (
      output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, pipe_empty,
             redirect_ready, csr_we, csr_addr, csr_wdata,
      input  exc_ready, flush, redirect_valid, redirect_pc, csr_rdata,
             trap_active, flush_timeout
   );

   modport slave (
      input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, pipe_empty,
             redirect_ready, csr_we, csr_addr, csr_wdata,
      output exc_ready, flush, redirect_valid, redirect_pc, csr_rdata,
             trap_active, flush_timeout
   );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap responder -- records trap CSRs, flushes the pipe, redirects fetch.
// Define TRAP_MTVAL_EN to implement the mtval CSR (0x343); otherwise it reads 0 and ignores writes.
module trap_controller #(
   parameter logic [31:0] RESET_MTVEC   = 32'h0000_0100,
   parameter int          FLUSH_TIMEOUT = 64
) (
   input logic   clk,
   input logic   reset,
   trap_if.slave bus
);
   localparam int            CW       = $clog2(FLUSH_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_TIMEOUT - 1);
   localparam logic [11:0]   A_MSTATUS = 12'h300;
   localparam logic [11:0]   A_MTVEC   = 12'h305;
   localparam logic [11:0]   A_MEPC    = 12'h341;
   localparam logic [11:0]   A_MCAUSE  = 12'h342;
   localparam logic [11:0]   A_MTVAL   = 12'h343;

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [31:0]   target, mtvec, mepc, mcause, mtval;
   logic          mie, mpie, to_flag;
   logic          take_exc, take_mret, timed_out;
   logic          wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;

   always_comb begin
      state_nx  = state;
      take_exc  = 1'b0;
      take_mret = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: begin
            take_exc  = bus.exc_valid;
            take_mret = bus.mret_valid & ~bus.exc_valid;
            if (take_exc | take_mret) state_nx = FLUSH;
         end
         FLUSH: begin
            timed_out = ~bus.pipe_empty & (cnt == CNT_LAST);
            if (bus.pipe_empty | timed_out) state_nx = REDIRECT;
         end
         REDIRECT: if (bus.redirect_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else       state <= state_nx;

   always_ff @(posedge clk)
      if (reset || state != FLUSH) cnt <= '0;
      else                         cnt <= cnt + 1'b1;

   // Target is frozen at acceptance; later CSR writes must not move the redirect.
   always_ff @(posedge clk)
      if (reset)          target <= '0;
      else if (take_exc)  target <= mtvec;
      else if (take_mret) target <= mepc;

   always_ff @(posedge clk)
      if (reset)          to_flag <= 1'b0;
      else if (timed_out) to_flag <= 1'b1;

   assign wr_mstatus = bus.csr_we & (bus.csr_addr == A_MSTATUS);
   assign wr_mtvec   = bus.csr_we & (bus.csr_addr == A_MTVEC);
   assign wr_mepc    = bus.csr_we & (bus.csr_addr == A_MEPC);
   assign wr_mcause  = bus.csr_we & (bus.csr_addr == A_MCAUSE);

   always_ff @(posedge clk)
      if (reset)         mtvec <= {RESET_MTVEC[31:2], 2'b00};
      else if (wr_mtvec) mtvec <= {bus.csr_wdata[31:2], 2'b00};

   // Trap/mret updates take priority over a CSR write landing on the same edge.
   always_ff @(posedge clk)
      if (reset)         mepc <= '0;
      else if (take_exc) mepc <= {bus.exc_pc[31:2], 2'b00};
      else if (wr_mepc)  mepc <= {bus.csr_wdata[31:2], 2'b00};

   always_ff @(posedge clk)
      if (reset)          mcause <= '0;
      else if (take_exc)  mcause <= bus.exc_cause;
      else if (wr_mcause) mcause <= bus.csr_wdata;

   always_ff @(posedge clk)
      if (reset) begin
         mie  <= 1'b0;
         mpie <= 1'b0;
      end else if (take_exc) begin
         mie  <= 1'b0;
         mpie <= mie;
      end else if (take_mret) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (wr_mstatus) begin
         mie  <= bus.csr_wdata[3];
         mpie <= bus.csr_wdata[7];
      end

`ifdef TRAP_MTVAL_EN
   logic wr_mtval;
   assign wr_mtval = bus.csr_we & (bus.csr_addr == A_MTVAL);
   always_ff @(posedge clk)
      if (reset)         mtval <= '0;
      else if (take_exc) mtval <= bus.exc_tval;
      else if (wr_mtval) mtval <= bus.csr_wdata;
`else
   logic unused_tval;
   assign mtval       = '0;
   assign unused_tval = ^bus.exc_tval;
`endif

   assign bus.csr_rdata = (bus.csr_addr == A_MSTATUS) ? {24'b0, mpie, 3'b0, mie, 3'b0} :
                          (bus.csr_addr == A_MTVEC)   ? mtvec  :
                          (bus.csr_addr == A_MEPC)    ? mepc   :
                          (bus.csr_addr == A_MCAUSE)  ? mcause :
                          (bus.csr_addr == A_MTVAL)   ? mtval  : 32'b0;

   assign bus.exc_ready      = state == IDLE;
   assign bus.flush          = state == FLUSH;
   assign bus.redirect_valid = state == REDIRECT;
   assign bus.redirect_pc    = (state == REDIRECT) ? target : 32'b0;
   assign bus.trap_active    = state != IDLE;
   assign bus.flush_timeout  = to_flag;
endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap responder for the core. Consumes exception requests from detectors such as the misaligned load/store checker. On each request it:
- records the trap CSRs (mepc, mcause, mtval, mstatus MIE/MPIE);
- drives a pipeline flush until the pipeline reports empty;
- issues a PC redirect to the trap vector.

It also handles `mret`, redirecting back to mepc. It sits between the exception sources and the fetch unit.

## Interface
Parameters:
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset; bits [1:0] forced 0.
- FLUSH_TIMEOUT, 64, maximum cycles spent in FLUSH waiting for pipe_empty; must be ≥ 2.

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  synchronous reset, active-high.
- Exception request:
  - exc_valid  in  1  exception request.
  - exc_cause  in  32  cause code (4 = load misaligned, 6 = store misaligned).
  - exc_pc  in  32  PC of faulting instruction.
  - exc_tval  in  32  faulting address/value.
  - mret_valid  in  1  mret request.
  - exc_ready  out  1  high only in IDLE; a request is accepted on valid & ready.
- Pipeline flush:
  - flush  out  1  pipeline flush, high throughout FLUSH.
  - pipe_empty  in  1  pipeline drained.
- PC redirect:
  - redirect_valid  out  1  redirect request, high throughout REDIRECT.
  - redirect_pc  out  32  redirect target.
  - redirect_ready  in  1  fetch accepts redirect.
- CSR access:
  - csr_we  in  1  CSR write enable.
  - csr_addr  in  12  CSR address.
  - csr_wdata  in  32  CSR write data.
  - csr_rdata  out  32  combinational read of csr_addr; unmapped addresses read 0.
- Status:
  - trap_active  out  1  state ≠ IDLE.
  - flush_timeout  out  1  sticky flag set when FLUSH ends by timeout.

## Operation
- **States:** IDLE, FLUSH, REDIRECT.
- **IDLE, exc_valid=1:**
  - Capture `mepc<=exc_pc` with [1:0] forced 0, `mcause<=exc_cause`, `mtval<=exc_tval`.
  - Update mstatus: `MPIE<=MIE`, `MIE<=0`.
  - Set target = mtvec; go to FLUSH.
- **IDLE, mret_valid=1 (exc_valid=0):**
  - Update mstatus: `MIE<=MPIE`, `MPIE<=1`.
  - Set target = mepc; go to FLUSH.
- **Both exc_valid and mret_valid high:** exception wins; mret is dropped.
- **FLUSH:**
  - flush=1; a cycle counter counts from 0.
  - Go to REDIRECT when pipe_empty=1 or the counter reaches FLUSH_TIMEOUT-1.
  - The timeout path sets flush_timeout.
- **REDIRECT:**
  - redirect_valid=1, redirect_pc=target; both held stable until redirect_ready.
  - On the handshake, go to IDLE.
- **CSR map:**
  - mstatus 0x300: only bit 3 (MIE) and bit 7 (MPIE) are implemented; other bits read 0.
  - mtvec 0x305.
  - mepc 0x341.
  - mcause 0x342.
  - mtval 0x343.
- **CSR writes:**
  - Accepted in any state.
  - Writes to mtvec/mepc force bits [1:0] to 0.
  - In the capture cycle, the trap/mret update wins over a csr_we write to the same register.
  - The latched target is not affected by CSR writes after capture.
- **Requests while not in IDLE:** exc_ready=0 and requests are ignored. Sources must hold the request until accepted.

## Timing
- **Reset values:**
  - Outputs: flush=0, redirect_valid=0, redirect_pc=0, exc_ready=1, trap_active=0, flush_timeout=0.
  - CSRs: mtvec=RESET_MTVEC, mepc=mcause=mtval=0, MIE=MPIE=0.
  - State: IDLE.
- **Latency:** request accepted at edge N. flush=1 from cycle N+1.
  - If pipe_empty=1 in N+1: redirect_valid=1 in N+2.
  - With redirect_ready=1 in N+2: IDLE and exc_ready=1 in N+3.
  - This is the minimum turnaround of 3 cycles.
- **pipe_empty:** sampled only in FLUSH; its value in IDLE or REDIRECT is ignored.
- **Timeout:** FLUSH lasts at most FLUSH_TIMEOUT cycles.
- **Reset mid-operation:** reset in any state returns to IDLE on the next edge. flush/redirect_valid deassert that same edge; no redirect is issued.
- **csr_rdata** reflects register contents after the last edge (no bypass of same-cycle writes).

## Configuration
- **TRAP_MTVAL_EN defined:** mtval is implemented and captured from exc_tval as described.
- **TRAP_MTVAL_EN undefined:**
  - No mtval register; exc_tval is unused.
  - Address 0x343 reads 0 and writes to it are ignored.
  - All other behaviour is unchanged.

## Test plan
- **Misaligned load trap:** exc_valid with cause=4, pc=0x200, tval=0x1002; pipe_empty=1 one cycle later.
  - flush high for 1 cycle; redirect_pc=0x100.
  - mepc=0x200, mcause=4, mtval=0x1002, MIE=0.
- **mret:** write mtvec=0x400 and mstatus.MIE=1, trap with pc=0x300, then mret.
  - First redirect to 0x400, then to 0x300.
  - MIE=1, MPIE=1 after the mret.
- **Flush timeout:** pipe_empty held 0.
  - flush high exactly 64 cycles, then REDIRECT; flush_timeout=1 until reset.
- **Simultaneous requests:** exc_valid and mret_valid together.
  - Exception taken; target=mtvec; mepc updated.
- **Backpressure:** redirect_ready low for 5 cycles.
  - redirect_valid and redirect_pc stable for those 5 cycles; exc_ready=0 throughout.
- **Reset in REDIRECT:** assert reset while in REDIRECT.
  - Next cycle: IDLE, redirect_valid=0, mtvec=0x100.
